// File: rtl/trax_move_rx.sv
// Trax link receiver: 8N1 UART deserialiser feeding an ASCII colour/move packet parser.
// Optional feature macro: TRAX_RX_PARITY_EN (8E1 framing with an even-parity check).
module trax_move_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int MAX_DIGITS   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic [21:0] move_out,
    output logic        color,
    output logic        end_receive,
    output logic        frame_err,
    output logic        pkt_err,
    output logic [2:0]  o_dbg_uart_state,
    output logic [2:0]  o_dbg_parse_state
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int ND_W  = $clog2(MAX_DIGITS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 1);

    localparam logic [2:0] U_IDLE   = 3'd0;
    localparam logic [2:0] U_START  = 3'd1;
    localparam logic [2:0] U_DATA   = 3'd2;
`ifdef TRAX_RX_PARITY_EN
    localparam logic [2:0] U_PARITY = 3'd3;
`endif
    localparam logic [2:0] U_STOP   = 3'd4;

    localparam logic [2:0] P_IDLE = 3'd0;
    localparam logic [2:0] P_ROW  = 3'd1;
    localparam logic [2:0] P_COL  = 3'd2;
    localparam logic [2:0] P_EOL  = 3'd4;
    localparam logic [2:0] P_ERR  = 3'd5;

    localparam logic [7:0] CH_W      = 8'h57;
    localparam logic [7:0] CH_B      = 8'h42;
    localparam logic [7:0] CH_LF     = 8'h0A;
    localparam logic [7:0] CH_CR     = 8'h0D;
    localparam logic [7:0] CH_COMMA  = 8'h2C;
    localparam logic [7:0] CH_PLUS   = 8'h2B;
    localparam logic [7:0] CH_SLASH  = 8'h2F;
    localparam logic [7:0] CH_BSLASH = 8'h5C;

    logic             r_rx_meta;
    logic             r_rx_sync;
    logic [2:0]       r_ustate;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_frame_err;
`ifdef TRAX_RX_PARITY_EN
    logic             r_par_err;
`endif

    logic             w_tick;
    logic             w_stop_sample;
    logic             w_byte_ok;
    logic             w_byte_valid;
    logic             w_byte_bad;
    logic [7:0]       w_byte;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    assign w_tick        = (r_cnt == LAST_CNT);
    assign w_stop_sample = (r_ustate == U_STOP) && w_tick;
`ifdef TRAX_RX_PARITY_EN
    assign w_byte_ok     = r_rx_sync && !r_par_err;
`else
    assign w_byte_ok     = r_rx_sync;
`endif
    assign w_byte_valid  = w_stop_sample && w_byte_ok;
    assign w_byte_bad    = w_stop_sample && !w_byte_ok;
    assign w_byte        = r_shift;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ustate    <= U_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
`ifdef TRAX_RX_PARITY_EN
            r_par_err   <= 1'b0;
`endif
        end else begin
            r_frame_err <= w_byte_bad;
            case (r_ustate)
                U_IDLE: begin
                    r_cnt <= '0;
                    if (!r_rx_sync) r_ustate <= U_START;
                end
                U_START: begin
                    // A start bit that is high again at mid-bit was a glitch
                    if (r_cnt == HALF_CNT) begin
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        r_ustate  <= r_rx_sync ? U_IDLE : U_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                U_DATA: begin
                    if (w_tick) begin
                        r_cnt     <= '0;
                        r_shift   <= {r_rx_sync, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 1'b1;
`ifdef TRAX_RX_PARITY_EN
                        if (r_bit_idx == 3'd7) r_ustate <= U_PARITY;
`else
                        if (r_bit_idx == 3'd7) r_ustate <= U_STOP;
`endif
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`ifdef TRAX_RX_PARITY_EN
                U_PARITY: begin
                    if (w_tick) begin
                        r_cnt     <= '0;
                        r_par_err <= r_rx_sync ^ (^r_shift);
                        r_ustate  <= U_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`endif
                U_STOP: begin
                    if (w_tick) begin
                        r_cnt    <= '0;
                        r_ustate <= U_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_ustate <= U_IDLE;
            endcase
        end
    end

    logic [2:0]      r_pstate;
    logic [10:0]     r_acc;
    logic [ND_W-1:0] r_ndig;
    logic [9:0]      r_row;
    logic [9:0]      r_col;
    logic [1:0]      r_tile;
    logic            r_is_color;
    logic            r_color_pend;
    logic [21:0]     r_move_out;
    logic            r_color;
    logic            r_end_receive;
    logic            r_pkt_err;

    logic        w_is_digit;
    logic        w_is_lf;
    logic        w_is_tile;
    logic [1:0]  w_tile_code;
    logic [13:0] w_acc_next;
    logic        w_ovf;
    logic [2:0]  w_p_next;
    logic        w_p_err;
    logic        w_commit;
    logic        w_first_digit;
    logic        w_take_digit;
    logic        w_latch_row;
    logic        w_latch_col;
    logic        w_latch_color;

    assign w_is_digit = (w_byte >= 8'h30) && (w_byte <= 8'h39);
    assign w_is_lf    = (w_byte == CH_LF);
    assign w_acc_next = ({3'd0, r_acc} * 14'd10) + {10'd0, w_byte[3:0]};
    assign w_ovf      = (r_ndig >= ND_W'(MAX_DIGITS)) || (w_acc_next > 14'd1023);

    always_comb begin
        w_tile_code = 2'b00;
        w_is_tile   = 1'b1;
        case (w_byte)
            CH_PLUS:   w_tile_code = 2'b01;
            CH_SLASH:  w_tile_code = 2'b10;
            CH_BSLASH: w_tile_code = 2'b11;
            default:   w_is_tile   = 1'b0;
        endcase
    end

    always_comb begin
        w_p_next      = r_pstate;
        w_p_err       = 1'b0;
        w_commit      = 1'b0;
        w_first_digit = 1'b0;
        w_take_digit  = 1'b0;
        w_latch_row   = 1'b0;
        w_latch_col   = 1'b0;
        w_latch_color = 1'b0;
        if (w_byte_bad) begin
            w_p_next = P_ERR;
            w_p_err  = (r_pstate != P_ERR);
        end else if (w_byte_valid && (w_byte != CH_CR)) begin
            case (r_pstate)
                P_IDLE: begin
                    if (w_byte == CH_W || w_byte == CH_B) begin
                        w_latch_color = 1'b1;
                        w_p_next      = P_EOL;
                    end else if (w_is_digit) begin
                        w_first_digit = 1'b1;
                        w_p_next      = P_ROW;
                    end else if (!w_is_lf) begin
                        w_p_err  = 1'b1;
                        w_p_next = P_ERR;
                    end
                end
                P_ROW, P_COL: begin
                    if (w_is_digit && !w_ovf) begin
                        w_take_digit = 1'b1;
                    end else if (r_pstate == P_ROW && w_byte == CH_COMMA && r_ndig != '0) begin
                        w_latch_row = 1'b1;
                        w_p_next    = P_COL;
                    end else if (r_pstate == P_COL && w_is_tile && r_ndig != '0) begin
                        w_latch_col = 1'b1;
                        w_p_next    = P_EOL;
                    end else begin
                        // A malformed line that already ended needs no further LF
                        w_p_err  = 1'b1;
                        w_p_next = w_is_lf ? P_IDLE : P_ERR;
                    end
                end
                P_EOL: begin
                    if (w_is_lf) begin
                        w_commit = 1'b1;
                        w_p_next = P_IDLE;
                    end else begin
                        w_p_err  = 1'b1;
                        w_p_next = P_ERR;
                    end
                end
                P_ERR: begin
                    if (w_is_lf) w_p_next = P_IDLE;
                end
                default: w_p_next = P_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pstate      <= P_IDLE;
            r_acc         <= '0;
            r_ndig        <= '0;
            r_row         <= '0;
            r_col         <= '0;
            r_tile        <= '0;
            r_is_color    <= 1'b0;
            r_color_pend  <= 1'b0;
            r_move_out    <= '0;
            r_color       <= 1'b0;
            r_end_receive <= 1'b1;
            r_pkt_err     <= 1'b0;
        end else begin
            r_pstate  <= w_p_next;
            r_pkt_err <= w_p_err;
            if (w_commit) begin
                r_end_receive <= 1'b1;
                if (r_is_color) r_color <= r_color_pend;
                else            r_move_out <= {r_tile, r_col, r_row};
            end else if (w_p_next != P_IDLE) begin
                r_end_receive <= 1'b0;
            end
            if (w_latch_color) begin
                r_is_color   <= 1'b1;
                r_color_pend <= (w_byte == CH_B);
            end
            if (w_first_digit) begin
                r_is_color <= 1'b0;
                r_acc      <= {7'd0, w_byte[3:0]};
                r_ndig     <= ND_W'(1);
            end
            if (w_take_digit) begin
                r_acc  <= w_acc_next[10:0];
                r_ndig <= r_ndig + ND_W'(1);
            end
            if (w_latch_row) begin
                r_row  <= r_acc[9:0];
                r_acc  <= '0;
                r_ndig <= '0;
            end
            if (w_latch_col) begin
                r_col  <= r_acc[9:0];
                r_tile <= w_tile_code;
            end
        end
    end

    assign move_out          = r_move_out;
    assign color             = r_color;
    assign end_receive       = r_end_receive;
    assign frame_err         = r_frame_err;
    assign pkt_err           = r_pkt_err;
    assign o_dbg_uart_state  = r_ustate;
    assign o_dbg_parse_state = r_pstate;

endmodule

// File: tb/tb_trax_move_rx.sv
// Directed bench for trax_move_rx at CLKS_PER_BIT=8; honours TRAX_RX_PARITY_EN for 8E1 framing.
module tb_trax_move_rx;

    localparam int CLKS = 8;

    logic        clk;
    logic        reset;
    logic        rx;
    logic [21:0] move_out;
    logic        color;
    logic        end_receive;
    logic        frame_err;
    logic        pkt_err;
    logic [2:0]  dbg_uart_state;
    logic [2:0]  dbg_parse_state;

    int n_vec;
    int n_err;
    int n_frame;
    int n_pkt;
    int n_rise;
    logic       prev_end;
    logic [2:0] prev_ustate;

    trax_move_rx #(.CLKS_PER_BIT(CLKS), .MAX_DIGITS(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .rx                (rx),
        .move_out          (move_out),
        .color             (color),
        .end_receive       (end_receive),
        .frame_err         (frame_err),
        .pkt_err           (pkt_err),
        .o_dbg_uart_state  (dbg_uart_state),
        .o_dbg_parse_state (dbg_parse_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pulse/edge monitor sampled just after each active edge
    always @(posedge clk) begin
        #1;
        if (frame_err) n_frame++;
        if (pkt_err)   n_pkt++;
        if (end_receive && !prev_end) begin
            n_rise++;
            if (!reset) check("rise_latency", 32'(prev_ustate), 32'd4);
        end
        prev_end    = end_receive;
        prev_ustate = dbg_uart_state;
    end

    task automatic clear_counts();
        n_frame = 0;
        n_pkt   = 0;
        n_rise  = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic par_flip);
        @(negedge clk);
        rx = 1'b0;
        repeat (CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CLKS) @(negedge clk);
        end
`ifdef TRAX_RX_PARITY_EN
        rx = (^b) ^ par_flip;
        repeat (CLKS) @(negedge clk);
`else
        if (par_flip) rx = 1'b1;
`endif
        rx = stop_bit;
        repeat (CLKS) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CLKS) @(negedge clk);
    endtask

    task automatic send_str(input string s);
        logic [7:0] b;
        for (int i = 0; i < s.len(); i++) begin
            b = s[i];
            send_byte(b, 1'b1, 1'b0);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        clear_counts();
        prev_end    = 1'b1;
        prev_ustate = 3'd0;
        reset = 1'b1;
        rx    = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_move_out", 32'(move_out), 32'h0);
        check("rst_color", 32'(color), 32'd0);
        check("rst_end_receive", 32'(end_receive), 32'd1);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_pkt_err", 32'(pkt_err), 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        clear_counts();

        // 1: colour packet "W\n"
        send_str("W");
        check("t1_end_low_after_W", 32'(end_receive), 32'd0);
        check("t1_no_rise_yet", 32'(n_rise), 32'd0);
        send_str("\n");
        check("t1_end_high", 32'(end_receive), 32'd1);
        check("t1_color", 32'(color), 32'd0);
        check("t1_move_out", 32'(move_out), 32'h0);
        check("t1_one_rise", 32'(n_rise), 32'd1);

        // 2: move packet, then colour packet with CR
        clear_counts();
        send_str("12,7/");
        check("t2_move_stable_pre_lf", 32'(move_out), 32'h0);
        check("t2_end_low_pre_lf", 32'(end_receive), 32'd0);
        send_str("\n");
        check("t2_move_out", 32'(move_out), 32'h201C0C);
        check("t2_one_rise", 32'(n_rise), 32'd1);
        clear_counts();
        send_str("B\r\n");
        check("t2_color_black", 32'(color), 32'd1);
        check("t2_move_kept", 32'(move_out), 32'h201C0C);
        check("t2_b_one_rise", 32'(n_rise), 32'd1);

        // 3: coordinate overflow, then recovery with backslash tile
        clear_counts();
        send_str("1024,3+\n");
        check("t3_pkt_err_once", 32'(n_pkt), 32'd1);
        check("t3_end_low", 32'(end_receive), 32'd0);
        check("t3_no_rise", 32'(n_rise), 32'd0);
        check("t3_move_kept", 32'(move_out), 32'h201C0C);
        clear_counts();
        send_str("0,0\\\n");
        check("t3_move_out", 32'(move_out), 32'h300000);
        check("t3_rise", 32'(n_rise), 32'd1);
        check("t3_end_high", 32'(end_receive), 32'd1);

        // 3b: five digits in a field
        clear_counts();
        send_str("00001,2+\n");
        check("t3b_pkt_err", 32'(n_pkt), 32'd1);
        check("t3b_no_rise", 32'(n_rise), 32'd0);
        check("t3b_move_kept", 32'(move_out), 32'h300000);

        // 4: bad stop bit inside "5,5+\n"
        clear_counts();
        send_byte(8'h35, 1'b1, 1'b0);
        send_byte(8'h2C, 1'b0, 1'b0);
        send_str("5+\n");
        check("t4_frame_err", 32'(n_frame), 32'd1);
        check("t4_pkt_err", 32'(n_pkt), 32'd1);
        check("t4_no_rise", 32'(n_rise), 32'd0);
        check("t4_move_kept", 32'(move_out), 32'h300000);
        clear_counts();
        send_str("5,5+\n");
        check("t4_move_out", 32'(move_out), 32'h101405);
        check("t4_rise", 32'(n_rise), 32'd1);
        check("t4_no_pkt_err", 32'(n_pkt), 32'd0);

`ifdef TRAX_RX_PARITY_EN
        // 6: parity error, then a correctly framed packet
        clear_counts();
        send_byte(8'h33, 1'b1, 1'b1);
        send_str(",4+\n");
        check("t6_frame_err", 32'(n_frame), 32'd1);
        check("t6_no_rise", 32'(n_rise), 32'd0);
        check("t6_move_kept", 32'(move_out), 32'h101405);
        clear_counts();
        send_str("3,4+\n");
        check("t6_move_out", 32'(move_out), 32'h101003);
        check("t6_rise", 32'(n_rise), 32'd1);
`endif

        // 5: start-bit glitch of two clocks
        clear_counts();
        @(negedge clk);
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CLKS) @(negedge clk);
        check("t5_glitch_frame", 32'(n_frame), 32'd0);
        check("t5_glitch_pkt", 32'(n_pkt), 32'd0);
        check("t5_glitch_uart_idle", 32'(dbg_uart_state), 32'd0);
        check("t5_glitch_end", 32'(end_receive), 32'd1);

        // 5b: reset in the middle of a byte inside a packet
        send_str("7");
        check("t5_mid_pkt_end_low", 32'(end_receive), 32'd0);
        @(negedge clk);
        rx = 1'b0;
        repeat (CLKS) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CLKS) @(negedge clk);
        clear_counts();
        reset = 1'b1;
        @(negedge clk);
        check("t5_rst_move_out", 32'(move_out), 32'h0);
        check("t5_rst_color", 32'(color), 32'd0);
        check("t5_rst_end", 32'(end_receive), 32'd1);
        check("t5_rst_frame_err", 32'(frame_err), 32'd0);
        check("t5_rst_pkt_err", 32'(pkt_err), 32'd0);
        reset = 1'b0;
        repeat (12 * CLKS) @(negedge clk);
        check("t5_no_frame_after_rst", 32'(n_frame), 32'd0);
        check("t5_no_pkt_after_rst", 32'(n_pkt), 32'd0);
        clear_counts();
        send_str("5,5+\n");
        check("t5_recover_move", 32'(move_out), 32'h101405);
        check("t5_recover_rise", 32'(n_rise), 32'd1);

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
